// File: rtl/font_rom_arbiter_if.sv
// Bundles the requester and ROM-side signals of font_rom_arbiter.
//   req/addr     : per-requester level request and flattened addresses
//   gnt/rvalid   : one-hot grant and one-hot read-data valid
//   rdata        : ROM row broadcast to all requesters
//   rom_address/rom_en/rom_data : single synchronous glyph ROM port
//   busy         : any request pending or read in flight
// master = renderers + ROM side, slave = arbiter.
interface font_rom_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 10,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      rom_address;
  logic               rom_en;
  logic [DW-1:0]      rom_data;
  logic               busy;

  modport master (
    output req, addr, rom_data,
    input  gnt, rvalid, rdata, rom_address, rom_en, busy
  );

  modport slave (
    input  req, addr, rom_data,
    output gnt, rvalid, rdata, rom_address, rom_en, busy
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous glyph ROM between NREQ
// character renderers. Each cycle one requester is granted the ROM port;
// a tag pipeline tracks the grant through the ROM latency and returns the
// row with a one-hot rvalid exactly ROM_LAT+1 cycles after gnt.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : font_rom_arbiter_if.slave (req, addr, gnt, rvalid, rdata,
//          rom_address, rom_en, rom_data, busy)
// Optional feature macro: FONT_ARB_PRIO0_EN -- requester 0 wins whenever it
// requests; requesters 1..NREQ-1 round-robin among themselves.
module font_rom_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = 10,
  parameter int unsigned DW      = 32,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  font_rom_arbiter_if.slave bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NS = ROM_LAT + 1;

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [NREQ-1:0]       gnt_q, gnt_d;
  logic [NREQ-1:0]       rvalid_q, rvalid_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [AW-1:0]         rom_address_q, rom_address_d;
  logic                  rom_en_q, rom_en_d;
  logic [NS-1:0]         tag_vld_q, tag_vld_d;
  logic [NS-1:0][PW-1:0] tag_idx_q, tag_idx_d;

  logic                  win_vld_c;
  logic [PW-1:0]         win_idx_c;
  logic                  ptr_adv_c;
  logic [NREQ-1:0]       rr_req_c;

  // Winner selection: scan from the pointer upward with wrap.
  always_comb begin
    logic [PW:0] cand;
    win_vld_c = 1'b0;
    win_idx_c = '0;
    ptr_adv_c = 1'b0;
    cand      = '0;
`ifdef FONT_ARB_PRIO0_EN
    // Requester 0 is excluded from the rotation and overrides it.
    rr_req_c  = bus.req & ~NREQ'(1);
`else
    rr_req_c  = bus.req;
`endif
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!win_vld_c && rr_req_c[cand[PW-1:0]]) begin
        win_vld_c = 1'b1;
        win_idx_c = cand[PW-1:0];
        ptr_adv_c = 1'b1;
      end
    end
`ifdef FONT_ARB_PRIO0_EN
    if (bus.req[0]) begin
      win_vld_c = 1'b1;
      win_idx_c = '0;
      ptr_adv_c = 1'b0;
    end
`endif
  end

  // Next-state: grant/ROM launch, tag shift, data return.
  always_comb begin
    ptr_d         = ptr_q;
    gnt_d         = '0;
    rom_en_d      = 1'b0;
    rom_address_d = rom_address_q;
    rvalid_d      = '0;
    rdata_d       = rdata_q;
    tag_vld_d     = {tag_vld_q[NS-2:0], win_vld_c};
    tag_idx_d     = {tag_idx_q[NS-2:0], win_idx_c};

    if (win_vld_c) begin
      gnt_d[win_idx_c] = 1'b1;
      rom_en_d         = 1'b1;
      rom_address_d    = bus.addr[int'(win_idx_c)*int'(AW) +: AW];
      if (ptr_adv_c) begin
        ptr_d = (win_idx_c == PW'(NREQ-1)) ? '0 : win_idx_c + PW'(1);
      end
    end

    // Last tag stage lines up with the ROM row being valid on rom_data.
    if (tag_vld_q[NS-1]) begin
      rvalid_d[tag_idx_q[NS-1]] = 1'b1;
      rdata_d                   = bus.rom_data;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q         <= '0;
      gnt_q         <= '0;
      rvalid_q      <= '0;
      rdata_q       <= '0;
      rom_address_q <= '0;
      rom_en_q      <= 1'b0;
      tag_vld_q     <= '0;
      tag_idx_q     <= '0;
    end else begin
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      rom_address_q <= rom_address_d;
      rom_en_q      <= rom_en_d;
      tag_vld_q     <= tag_vld_d;
      tag_idx_q     <= tag_idx_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.rvalid      = rvalid_q;
  assign bus.rdata       = rdata_q;
  assign bus.rom_address = rom_address_q;
  assign bus.rom_en      = rom_en_q;
  assign bus.busy        = (|bus.req) | (|tag_vld_q) | rom_en_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Scoreboard bench for font_rom_arbiter: two instances (ROM_LAT=1 and 3)
// share identical request stimulus; expected grants and returned rows are
// queued by the stimulus and checked by a negedge monitor.
module tb_font_rom_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  font_rom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus1 ();
  font_rom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus3 ();

  font_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  font_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3));

  function automatic logic [DW-1:0] rom_row(input logic [AW-1:0] a);
    return {6'h2A, a, 6'h15, ~a};
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh;
  endfunction

  // Glyph ROM models, latency 1 and 3.
  logic [DW-1:0] p1;
  logic [DW-1:0] p3 [3];
  always @(posedge clk) begin
    p1    <= rom_row(bus1.rom_address);
    p3[0] <= rom_row(bus3.rom_address);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus1.rom_data = p1;
  assign bus3.rom_data = p3[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int idx; logic [AW-1:0] a; } gexp_t;
  typedef struct { int cyc; int idx; logic [DW-1:0] row; } rexp_t;
  gexp_t gq[$];
  rexp_t rq1[$];
  rexp_t rq3[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Drive one cycle of requests; w is the hand-computed winner (-1 = none).
  task automatic drive(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a, input int w);
    logic [AW-1:0] aw;
    @(negedge clk);
    bus1.req  = r;
    bus3.req  = r;
    bus1.addr = a;
    bus3.addr = a;
    if (w >= 0) begin
      aw = a[w*AW +: AW];
      gq.push_back('{cyc + 1, w, aw});
      rq1.push_back('{cyc + 3, w, rom_row(aw)});
      rq3.push_back('{cyc + 5, w, rom_row(aw)});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, -1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt1"}, 64'(bus1.gnt), 64'(0));
    chk({tag, "_gnt3"}, 64'(bus3.gnt), 64'(0));
    chk({tag, "_rvalid1"}, 64'(bus1.rvalid), 64'(0));
    chk({tag, "_rvalid3"}, 64'(bus3.rvalid), 64'(0));
    chk({tag, "_rdata1"}, 64'(bus1.rdata), 64'(0));
    chk({tag, "_rdata3"}, 64'(bus3.rdata), 64'(0));
    chk({tag, "_romaddr1"}, 64'(bus1.rom_address), 64'(0));
    chk({tag, "_romen1"}, 64'(bus1.rom_en), 64'(0));
    chk({tag, "_romen3"}, 64'(bus3.rom_en), 64'(0));
    chk({tag, "_busy1"}, 64'(bus1.busy), 64'(0));
    chk({tag, "_busy3"}, 64'(bus3.busy), 64'(0));
  endtask

  // Monitor: compare every cycle against the queue fronts.
  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    logic            has;
    logic [AW-1:0]   ea;
    logic [NREQ-1:0] ev;
    logic [DW-1:0]   er;
    has = 1'b0;
    eg  = '0;
    ea  = '0;
    if (gq.size() > 0 && gq[0].cyc == cyc) begin
      has = 1'b1;
      eg  = onehot(gq[0].idx);
      ea  = gq[0].a;
      void'(gq.pop_front());
    end
    chk("gnt1", 64'(bus1.gnt), 64'(eg));
    chk("gnt3", 64'(bus3.gnt), 64'(eg));
    chk("rom_en1", 64'(bus1.rom_en), 64'(has));
    chk("rom_en3", 64'(bus3.rom_en), 64'(has));
    if (has) begin
      chk("rom_address1", 64'(bus1.rom_address), 64'(ea));
      chk("rom_address3", 64'(bus3.rom_address), 64'(ea));
    end

    ev = '0;
    if (rq1.size() > 0 && rq1[0].cyc == cyc) begin
      ev = onehot(rq1[0].idx);
      er = rq1[0].row;
      void'(rq1.pop_front());
      chk("rdata1", 64'(bus1.rdata), 64'(er));
    end
    chk("rvalid1", 64'(bus1.rvalid), 64'(ev));

    ev = '0;
    if (rq3.size() > 0 && rq3[0].cyc == cyc) begin
      ev = onehot(rq3[0].idx);
      er = rq3[0].row;
      void'(rq3.pop_front());
      chk("rdata3", 64'(bus3.rdata), 64'(er));
    end
    chk("rvalid3", 64'(bus3.rvalid), 64'(ev));
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ*AW-1:0] a;
    logic [NREQ*AW-1:0] a2;
    a  = {10'h3C3, 10'h2A2, 10'h151, 10'h0F0};
    a2 = {10'h000, 10'h155, 10'h000, 10'h000};
    bus1.req = '0; bus3.req = '0; bus1.addr = '0; bus3.addr = '0;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

`ifdef FONT_ARB_PRIO0_EN
    // Requester 0 preempts; 1..3 rotate in the remaining slots.
    drive(4'b1111, a, 0); drive(4'b1110, a, 1);
    drive(4'b1111, a, 0); drive(4'b1110, a, 2);
    drive(4'b1111, a, 0); drive(4'b1110, a, 3);
    drive(4'b1111, a, 0); drive(4'b1110, a, 1);
    drive('0, a, -1);
    idle(6);
`else
    // All requesting: strict rotation 0..3, twice.
    for (int i = 0; i < 8; i++) drive(4'b1111, a, i % 4);
    drive('0, a, -1);
    chk("busy_inflight1", 64'(bus1.busy), 64'(1));
    chk("busy_inflight3", 64'(bus3.busy), 64'(1));
    idle(5);

    // Single read from requester 2, dropped in the gnt cycle.
    drive(4'b0100, a2, 2);
    drive('0, a2, -1);
    idle(5);
    chk("addr_hold1", 64'(bus1.rom_address), 64'(10'h155));
    chk("addr_hold3", 64'(bus3.rom_address), 64'(10'h155));

    // Pointer wrap after a grant to 3.
    drive(4'b1000, a, 3);
    drive(4'b1001, a, 0);
    drive(4'b1000, a, 3);
    drive('0, a, -1);
    idle(4);

    // Continuous 0110: alternate 1,2 back to back.
    for (int i = 0; i < 6; i++) drive(4'b0110, a, (i % 2 == 0) ? 1 : 2);
    drive('0, a, -1);
    idle(6);

    // Async reset with two reads in flight.
    drive(4'b0011, a, 0);
    drive(4'b0011, a, 1);
    @(posedge clk);
    #2;
    bus1.req = '0; bus3.req = '0;
    rst = 1'b1;
    #1;
    chk_zero("midreset");
    gq.delete(); rq1.delete(); rq3.delete();
    drive(4'b0110, a, -1);
    drive(4'b0110, a, 1);
    rst = 1'b0;
    drive('0, a, -1);
    idle(6);
`endif

    chk("gq_empty", 64'(gq.size()), 64'(0));
    chk("rq1_empty", 64'(rq1.size()), 64'(0));
    chk("rq3_empty", 64'(rq3.size()), 64'(0));
    chk("busy_idle1", 64'(bus1.busy), 64'(0));
    chk("busy_idle3", 64'(bus3.busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
